cdc_irq_bank: RTL and testbench
===============================

Name: cdc_irq_bank

Overview:
- Multi-channel interrupt crossing from the interrupt/source clock domain (int_clk) to the system/CPU clock domain (clk).
- Each channel uses a 4-phase-free toggle request/acknowledge handshake with SYNC_STAGES-deep synchronisers in both directions.
- Provides per-channel pending, mask and a combined interrupt output.
- Sits between peripheral event sources and the MPU interrupt controller; replaces single-bit latch-style crossings.

Parameters:
- CHANNELS, 8: number of independent interrupt channels (1..32).
- SYNC_STAGES, 3: flops per synchroniser chain, each direction (min 2).

Ports:
- int_clk  in  1  source/interrupt domain clock
- clk  in  1  system domain clock
- reset_n  in  1  asynchronous, active-low reset, both domains
- trigger  in  CHANNELS  int_clk domain; per-channel event, sampled every int_clk edge
- overrun_clr  in  CHANNELS  int_clk domain; clears matching overrun bits
- busy  out  CHANNELS  int_clk domain; request in flight, not yet acknowledged back
- overrun  out  CHANNELS  int_clk domain; sticky, trigger arrived while busy
- mask  in  CHANNELS  clk domain; 1 = channel enabled onto irq
- ack  in  CHANNELS  clk domain; acknowledge pending channel
- pending  out  CHANNELS  clk domain; request received, not yet acked
- irq  out  1  clk domain; OR of (pending & mask)

Behaviour:
- Reset: reset_n is asynchronous, active-low, clock int_clk. While low, all state clears in both domains: req_tgl, ack_tgl, sync chains, busy, overrun, pending, irq and re-arm flags are all 0. Deassertion is pre-synchronised per domain externally.
- Mid-operation reset discards in-flight requests. All toggles return to 0 together, so there are no spurious edges after release.
- Source side, per channel n, at a posedge int_clk:
  - trigger[n] & !busy[n]: req_tgl[n] flips; busy[n] <= 1.
  - trigger[n] & busy[n]: see Optional Feature.
  - Synchronised ack_tgl[n] differs from the local copy: busy[n] <= 0 and the local copy updates. If trigger[n] is high on that same edge, it is treated as busy (dropped or re-armed).
  - overrun_clr[n] clears overrun[n]; a simultaneous set wins.
- Crossing: req_tgl passes through SYNC_STAGES flops on clk, then one edge-detect flop. ack_tgl passes through SYNC_STAGES flops on int_clk, then edge compare.
- Sink side, at a posedge clk:
  - Detected req edge: pending[n] <= 1.
  - ack[n] & pending[n]: pending[n] <= 0; ack_tgl[n] flips.
  - ack[n] with pending[n] = 0: ignored, no toggle.
  - Set and ack on the same edge cannot occur for one channel, because the handshake forbids it. If it does occur, set wins and ack is ignored.
- irq is the combinational OR of registered pending & mask. Masking does not clear pending.
- Latency:
  - trigger to pending: 1 int_clk edge, then SYNC_STAGES+1 clk edges (+1 clk for metastability resolution).
  - ack to busy low: 1 clk edge, then SYNC_STAGES+1 int_clk edges (+1).
- Channels are fully independent; no priority or ordering between channels.
- Maximum event rate per channel is one per full round trip. Faster events are handled per the Optional Feature.

Optional Feature:
- IRQ_COALESCE_EN defined:
  - trigger while busy sets rearm[n] (and also overrun[n]).
  - When busy clears, if rearm[n] = 1, req_tgl[n] flips on that same edge, busy stays 1 and rearm[n] clears. Exactly one follow-up request is issued however many triggers were coalesced.
- Undefined:
  - trigger while busy is dropped; only overrun[n] sets.
  - No rearm logic is synthesised.

Test Plan:
- CHANNELS=4, SYNC_STAGES=3, clk 100 MHz, int_clk 33 MHz:
  - 1-cycle trigger=4'b0001 -> busy[0]=1 next int_clk edge; pending=4'b0001 within 4-5 clk edges.
  - With mask=4'b0001, irq=1. Then ack=4'b0001 for one cycle -> pending=0 and irq=0 next clk edge; busy[0]=0 within 4-5 int_clk edges.
- mask=4'b0000, trigger=4'b0100 -> pending=4'b0100, irq=0. Set mask=4'b0100 -> irq=1 same cycle. Pending persists until ack.
- Second trigger on ch1 while busy[1]=1:
  - Without macro: overrun[1]=1 and exactly one pending pulse over the full handshake. overrun_clr[1] -> overrun[1]=0.
  - With IRQ_COALESCE_EN: after ack, pending[1] reasserts once; three extra triggers still yield exactly 2 pendings total.
- ack=4'b1000 while pending=0 -> no state change; busy/ack_tgl unchanged; a later trigger on ch3 still handshakes normally.
- reset_n low for 2 cycles while ch2 is mid-handshake (pending[2]=1, busy[2]=1) -> all outputs 0. After release, no spurious pending over 20 clk cycles; a new trigger on ch2 completes normally.
- Clock swap stress: int_clk 150 MHz, clk 25 MHz, random triggers on all 4 channels for 10k cycles -> per channel, pending rise count equals accepted requests; no lost ack and no stuck busy.

Source files
------------

// File: rtl/cdc_irq_bank_if.sv
// cdc_irq_bank_if: bundle of the per-channel interrupt signals crossing between
// the event-source domain (trigger/overrun side) and the system domain
// (mask/ack/pending/irq side).
interface cdc_irq_bank_if #(
  parameter int unsigned CHANNELS = 8
);
  // int_clk domain
  logic [CHANNELS-1:0] trigger;
  logic [CHANNELS-1:0] overrun_clr;
  logic [CHANNELS-1:0] busy;
  logic [CHANNELS-1:0] overrun;
  // clk domain
  logic [CHANNELS-1:0] mask;
  logic [CHANNELS-1:0] ack;
  logic [CHANNELS-1:0] pending;
  logic                irq;

  modport master (
    output trigger, overrun_clr, mask, ack,
    input  busy, overrun, pending, irq
  );

  modport slave (
    input  trigger, overrun_clr, mask, ack,
    output busy, overrun, pending, irq
  );
endinterface

// File: rtl/cdc_irq_bank.sv
// cdc_irq_bank: multi-channel interrupt crossing from int_clk to clk.
// Each channel runs a toggle request/acknowledge handshake with SYNC_STAGES-deep
// synchronisers in both directions. The sink keeps per-channel pending bits and
// drives irq = |(pending & mask).
// Optional feature macro: IRQ_COALESCE_EN -- triggers arriving while a request
// is in flight are folded into exactly one follow-up request. Without it they
// are dropped and only flagged through overrun.
module cdc_irq_bank #(
  parameter int unsigned CHANNELS    = 8,
  parameter int unsigned SYNC_STAGES = 3
) (
  input logic            int_clk,
  input logic            clk,
  input logic            reset_n,
  cdc_irq_bank_if.slave  io_bus
);

  localparam int unsigned LastStage = SYNC_STAGES - 1;

  typedef logic [CHANNELS-1:0] chan_t;

  // Source-domain state
  chan_t r_req_tgl;
  chan_t r_busy;
  chan_t r_overrun;
  chan_t r_ack_seen;
  chan_t r_ack_sync [SYNC_STAGES];

  // Sink-domain state
  chan_t r_req_sync [SYNC_STAGES];
  chan_t r_req_seen;
  chan_t r_ack_tgl;
  chan_t r_pending;

  chan_t w_ack_edge;
  chan_t w_start;
  chan_t w_trig_busy;
  chan_t w_refire;
  chan_t w_req_edge;
  chan_t w_ack_ok;

  // An acknowledge toggle arriving back ends the in-flight request.
  assign w_ack_edge  = r_ack_sync[LastStage] ^ r_ack_seen;
  // A trigger on the ack-return edge still sees busy=1, so it counts as busy.
  assign w_start     = io_bus.trigger & ~r_busy;
  assign w_trig_busy = io_bus.trigger & r_busy;

`ifdef IRQ_COALESCE_EN
  chan_t r_rearm;
  chan_t w_rearm_any;

  // Includes a trigger landing on the very edge the ack returns.
  assign w_rearm_any = r_rearm | w_trig_busy;
  assign w_refire    = w_ack_edge & w_rearm_any;

  // Remember that at least one trigger was absorbed while busy.
  always_ff @(posedge int_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rearm <= '0;
    end else begin
      r_rearm <= w_rearm_any & ~w_ack_edge;
    end
  end
`else
  assign w_refire = '0;
`endif

  // Source side: request toggle, busy, sticky overrun and ack synchroniser.
  always_ff @(posedge int_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req_tgl  <= '0;
      r_busy     <= '0;
      r_overrun  <= '0;
      r_ack_seen <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_ack_sync[i] <= '0;
      end
    end else begin
      // start and refire are mutually exclusive (busy=0 vs busy=1)
      r_req_tgl  <= r_req_tgl ^ w_start ^ w_refire;
      r_busy     <= (r_busy & ~w_ack_edge) | w_start | w_refire;
      // a set on the same edge as a clear wins
      r_overrun  <= (r_overrun & ~io_bus.overrun_clr) | w_trig_busy;
      r_ack_seen <= r_ack_sync[LastStage];
      r_ack_sync[0] <= r_ack_tgl;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_ack_sync[i] <= r_ack_sync[i-1];
      end
    end
  end

  // A request edge sets pending; an ack clears it only if pending and not
  // colliding with a new set (set wins).
  assign w_req_edge = r_req_sync[LastStage] ^ r_req_seen;
  assign w_ack_ok   = io_bus.ack & r_pending & ~w_req_edge;

  // Sink side: request synchroniser, edge-detect flop, pending and ack toggle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req_seen <= '0;
      r_ack_tgl  <= '0;
      r_pending  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_req_sync[i] <= '0;
      end
    end else begin
      r_req_seen <= r_req_sync[LastStage];
      r_pending  <= w_req_edge | (r_pending & ~w_ack_ok);
      r_ack_tgl  <= r_ack_tgl ^ w_ack_ok;
      r_req_sync[0] <= r_req_tgl;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_req_sync[i] <= r_req_sync[i-1];
      end
    end
  end

  assign io_bus.busy    = r_busy;
  assign io_bus.overrun = r_overrun;
  assign io_bus.pending = r_pending;
  // Masking only gates the output; pending is left untouched.
  assign io_bus.irq     = |(r_pending & io_bus.mask);

endmodule

// File: tb/tb_cdc_irq_bank.sv
// Bench for cdc_irq_bank: 4 channels, 3-stage synchronisers. Expected pending
// pulses are queued when triggers are driven and matched off as pending rises.
// Time unit is arbitrary: 30 units = 10 ns.
module tb_cdc_irq_bank;

  localparam int NCh         = 4;
  localparam int NSync       = 3;
  localparam int StressIters = 250;

  logic int_clk = 1'b0;
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   int_half = 45;  // 33 MHz
  int   clk_half = 15;  // 100 MHz

  cdc_irq_bank_if #(.CHANNELS(NCh)) bus ();

  logic           auto_ack = 1'b0;
  logic [NCh-1:0] man_ack  = '0;
  assign bus.ack = auto_ack ? bus.pending : man_ack;

  cdc_irq_bank #(
    .CHANNELS    (NCh),
    .SYNC_STAGES (NSync)
  ) u_dut (
    .int_clk (int_clk),
    .clk     (clk),
    .reset_n (reset_n),
    .io_bus  (bus)
  );

  always #(int_half) int_clk = ~int_clk;
  always #(clk_half) clk = ~clk;

  int total = 0;
  int bad   = 0;
  int sb_q [$];
  int rise_cnt [NCh];
  int consumed [NCh];
  logic [NCh-1:0] pend_prev = '0;

  // Count pending rising edges per channel, sampled mid-cycle.
  always @(negedge clk) begin
    for (int c = 0; c < NCh; c++) begin
      if (bus.pending[c] === 1'b1 && pend_prev[c] !== 1'b1) rise_cnt[c]++;
    end
    pend_prev = bus.pending;
  end

  function automatic bit sb_take(input int c);
    for (int i = 0; i < sb_q.size(); i++) begin
      if (sb_q[i] == c) begin
        sb_q.delete(i);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic wait_rise(input int c, input int budget, output bit ok);
    int n;
    n = 0;
    while (rise_cnt[c] <= consumed[c] && n < budget) begin
      @(posedge clk);
      n++;
    end
    ok = rise_cnt[c] > consumed[c];
    if (ok) consumed[c]++;
  endtask

  task automatic pulse_trigger(input int c, input int cycles);
    @(posedge int_clk);
    #1;
    bus.trigger[c] = 1'b1;
    repeat (cycles) @(posedge int_clk);
    #1;
    bus.trigger[c] = 1'b0;
  endtask

  task automatic wait_idle(input int c, input int budget, output int n);
    n = 0;
    while (bus.busy[c] !== 1'b0 && n < budget) begin
      @(posedge int_clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge int_clk);
    #1;
    total++;
    if (bus.busy !== 4'b0000) begin bad++; $display("FAIL reset_busy: got %b want 0000", bus.busy); end
    total++;
    if (bus.overrun !== 4'b0000) begin bad++; $display("FAIL reset_overrun: got %b want 0000", bus.overrun); end
    total++;
    if (bus.pending !== 4'b0000) begin bad++; $display("FAIL reset_pending: got %b want 0000", bus.pending); end
    total++;
    if (bus.irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", bus.irq); end
    #6;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic();
    int n;
    bit ok, took;
    bus.mask = 4'b0001;
    pulse_trigger(0, 1);
    sb_q.push_back(0);
    total++;
    if (bus.busy !== 4'b0001) begin bad++; $display("FAIL basic_busy_set: got %b want 0001", bus.busy); end
    n = 0;
    while (bus.pending[0] !== 1'b1 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (n < 4 || n > 5) begin bad++; $display("FAIL basic_req_latency: got %0d clk edges want 4..5", n); end
    wait_rise(0, 4, ok);
    took = ok && sb_take(0);
    total++;
    if (!took) begin bad++; $display("FAIL basic_rise: got seen=%0b want 1", ok); end
    #1;
    total++;
    if (bus.pending !== 4'b0001) begin bad++; $display("FAIL basic_pending: got %b want 0001", bus.pending); end
    total++;
    if (bus.irq !== 1'b1) begin bad++; $display("FAIL basic_irq: got %b want 1", bus.irq); end
    @(posedge clk);
    #1;
    man_ack = 4'b0001;
    @(posedge clk);
    #1;
    man_ack = 4'b0000;
    total++;
    if (bus.pending !== 4'b0000 || bus.irq !== 1'b0) begin
      bad++; $display("FAIL basic_ack_clear: got pending=%b irq=%b want 0000/0", bus.pending, bus.irq);
    end
    wait_idle(0, 12, n);
    total++;
    if (n < 4 || n > 5) begin bad++; $display("FAIL basic_ack_latency: got %0d int_clk edges want 4..5", n); end
  endtask

  task automatic test_mask();
    int n;
    bit ok, took;
    bus.mask = 4'b0000;
    pulse_trigger(2, 1);
    sb_q.push_back(2);
    wait_rise(2, 12, ok);
    took = ok && sb_take(2);
    total++;
    if (!took) begin bad++; $display("FAIL mask_rise: got seen=%0b want 1", ok); end
    @(posedge clk);
    #1;
    total++;
    if (bus.pending !== 4'b0100 || bus.irq !== 1'b0) begin
      bad++; $display("FAIL mask_off: got pending=%b irq=%b want 0100/0", bus.pending, bus.irq);
    end
    bus.mask = 4'b0100;
    #1;
    total++;
    if (bus.irq !== 1'b1) begin bad++; $display("FAIL mask_on_irq: got %b want 1", bus.irq); end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (bus.pending !== 4'b0100) begin bad++; $display("FAIL mask_persist: got %b want 0100", bus.pending); end
    man_ack = 4'b0100;
    @(posedge clk);
    #1;
    man_ack = 4'b0000;
    total++;
    if (bus.pending !== 4'b0000) begin bad++; $display("FAIL mask_ack: got %b want 0000", bus.pending); end
    wait_idle(2, 12, n);
    total++;
    if (bus.busy !== 4'b0000) begin bad++; $display("FAIL mask_busy_clear: got %b want 0000", bus.busy); end
  endtask

  task automatic test_overrun();
    int base, nexp;
    bit ok, took;
    auto_ack = 1'b1;
    bus.mask = 4'b1111;
    base = rise_cnt[1];
    // one accepted trigger followed by three while busy
    pulse_trigger(1, 4);
    sb_q.push_back(1);
    nexp = 1;
`ifdef IRQ_COALESCE_EN
    sb_q.push_back(1);
    nexp = 2;
`endif
    total++;
    if (bus.overrun[1] !== 1'b1 || bus.busy[1] !== 1'b1) begin
      bad++; $display("FAIL ovr_set: got overrun=%b busy=%b want 1/1", bus.overrun[1], bus.busy[1]);
    end
    for (int k = 0; k < nexp; k++) begin
      wait_rise(1, 40, ok);
      took = ok && sb_take(1);
      total++;
      if (!took) begin bad++; $display("FAIL ovr_rise%0d: got seen=%0b want 1", k, ok); end
    end
    repeat (40) @(posedge clk);
    #1;
    total++;
    if (rise_cnt[1] - base != nexp) begin
      bad++; $display("FAIL ovr_pend_count: got %0d want %0d", rise_cnt[1] - base, nexp);
    end
    total++;
    if (bus.busy[1] !== 1'b0) begin bad++; $display("FAIL ovr_busy_clear: got %b want 0", bus.busy[1]); end
    @(posedge int_clk);
    #1;
    bus.overrun_clr = 4'b0010;
    @(posedge int_clk);
    #1;
    bus.overrun_clr = 4'b0000;
    total++;
    if (bus.overrun !== 4'b0000) begin bad++; $display("FAIL ovr_clear: got %b want 0000", bus.overrun); end
    auto_ack = 1'b0;
  endtask

  task automatic test_spurious_ack();
    int base, n;
    bit ok, took;
    auto_ack = 1'b0;
    base = rise_cnt[3];
    @(posedge clk);
    #1;
    man_ack = 4'b1000;
    @(posedge clk);
    #1;
    man_ack = 4'b0000;
    repeat (20) @(posedge int_clk);
    #1;
    total++;
    if (bus.busy !== 4'b0000 || bus.pending !== 4'b0000 || rise_cnt[3] != base) begin
      bad++; $display("FAIL spur_ack_idle: got busy=%b pending=%b rises=%0d want 0000/0000/%0d",
                      bus.busy, bus.pending, rise_cnt[3], base);
    end
    auto_ack = 1'b1;
    pulse_trigger(3, 1);
    sb_q.push_back(3);
    total++;
    if (bus.busy !== 4'b1000) begin bad++; $display("FAIL spur_busy_set: got %b want 1000", bus.busy); end
    wait_rise(3, 12, ok);
    took = ok && sb_take(3);
    total++;
    if (!took) begin bad++; $display("FAIL spur_rise: got seen=%0b want 1", ok); end
    wait_idle(3, 20, n);
    total++;
    if (bus.busy !== 4'b0000) begin bad++; $display("FAIL spur_busy_clear: got %b want 0000", bus.busy); end
    auto_ack = 1'b0;
  endtask

  task automatic test_mid_reset();
    int base, n;
    bit ok, took;
    auto_ack = 1'b0;
    bus.mask = 4'b0100;
    pulse_trigger(2, 1);
    sb_q.push_back(2);
    wait_rise(2, 12, ok);
    took = ok && sb_take(2);
    total++;
    if (!took) begin bad++; $display("FAIL rst_pre_rise: got seen=%0b want 1", ok); end
    @(posedge clk);
    #1;
    total++;
    if (bus.busy[2] !== 1'b1 || bus.pending[2] !== 1'b1) begin
      bad++; $display("FAIL rst_inflight: got busy=%b pending=%b want 1/1", bus.busy[2], bus.pending[2]);
    end
    @(posedge int_clk);
    #3;
    reset_n = 1'b0;
    #1;
    total++;
    if (bus.busy !== 4'b0000 || bus.pending !== 4'b0000 || bus.irq !== 1'b0 || bus.overrun !== 4'b0000) begin
      bad++; $display("FAIL rst_outputs: got busy=%b pending=%b irq=%b overrun=%b want all 0",
                      bus.busy, bus.pending, bus.irq, bus.overrun);
    end
    repeat (2) @(posedge int_clk);
    #7;
    reset_n = 1'b1;
    base = rise_cnt[2];
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (rise_cnt[2] != base || bus.pending !== 4'b0000) begin
      bad++; $display("FAIL rst_no_spurious: got rises=%0d pending=%b want %0d/0000",
                      rise_cnt[2], bus.pending, base);
    end
    auto_ack = 1'b1;
    pulse_trigger(2, 1);
    sb_q.push_back(2);
    wait_rise(2, 12, ok);
    took = ok && sb_take(2);
    total++;
    if (!took) begin bad++; $display("FAIL rst_post_rise: got seen=%0b want 1", ok); end
    wait_idle(2, 20, n);
    total++;
    if (bus.busy !== 4'b0000) begin bad++; $display("FAIL rst_post_idle: got %b want 0000", bus.busy); end
    auto_ack = 1'b0;
  endtask

  task automatic stress_chan(input int c);
    int gap, extra, nexp;
    bit ok, took;
    for (int it = 0; it < StressIters; it++) begin
      gap   = int'($urandom_range(0, 3));
      extra = int'($urandom_range(0, 2));
      repeat (gap) @(posedge int_clk);
      pulse_trigger(c, 1 + extra);
      sb_q.push_back(c);
      nexp = 1;
`ifdef IRQ_COALESCE_EN
      if (extra > 0) begin
        sb_q.push_back(c);
        nexp = 2;
      end
`endif
      for (int k = 0; k < nexp; k++) begin
        wait_rise(c, 20, ok);
        took = ok && sb_take(c);
        total++;
        if (!took) begin
          bad++; $display("FAIL stress_rise ch%0d it%0d: got seen=%0b want 1", c, it, ok);
        end
      end
      // ack lands on the next clk edge, then crosses back
      repeat (2) @(posedge clk);
      repeat (NSync + 3) @(posedge int_clk);
      #1;
      total++;
      if (bus.busy[c] !== 1'b0 || rise_cnt[c] != consumed[c]) begin
        bad++; $display("FAIL stress_idle ch%0d it%0d: got busy=%b rises=%0d want 0/%0d",
                        c, it, bus.busy[c], rise_cnt[c], consumed[c]);
      end
    end
  endtask

  task automatic test_stress();
    int_half = 10;  // 150 MHz
    clk_half = 60;  // 25 MHz
    auto_ack = 1'b1;
    bus.mask = 4'b1111;
    repeat (4) @(posedge clk);
    fork
      stress_chan(0);
      stress_chan(1);
      stress_chan(2);
      stress_chan(3);
    join
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (sb_q.size() != 0) begin bad++; $display("FAIL stress_sb_empty: got %0d left want 0", sb_q.size()); end
    total++;
    if (bus.busy !== 4'b0000 || bus.pending !== 4'b0000) begin
      bad++; $display("FAIL stress_final: got busy=%b pending=%b want 0000/0000", bus.busy, bus.pending);
    end
  endtask

  initial begin
    bus.trigger     = '0;
    bus.overrun_clr = '0;
    bus.mask        = '0;
    for (int c = 0; c < NCh; c++) begin
      rise_cnt[c] = 0;
      consumed[c] = 0;
    end
    test_reset();
    test_basic();
    test_mask();
    test_overrun();
    test_spurious_ack();
    test_mid_reset();
    test_stress();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
